icache_dm: RTL and testbench

//  Direct-mapped instruction cache; the responder side of the IFQ fetch interface.
//  - Accepts a fetch address on pc_in/rd_en and returns the aligned 128-bit line on D_out/d_out_valid.
//  - On a miss, refills the line from a 32-bit memory port in 4 beats, then responds.
//  - Sits between the IFQ and the instruction memory.

---
 rtl/ifq_pkg.sv | 28 ++
 rtl/icache_line_store.sv | 49 ++++
 rtl/icache_dm.sv | 153 +++++++++++++++
 tb/tb_icache_dm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch path (IFQ <-> icache_dm).
package ifq_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 4;
  localparam int unsigned INDEX_W        = 4;
  localparam int unsigned TAG_W          = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESPOND
  } icache_state_t;

  // Field view of a fetch address for the default 16-line geometry.
  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } fetch_addr_t;

  function automatic fetch_addr_t split_addr(input logic [ADDR_W-1:0] addr);
    return fetch_addr_t'(addr);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped cache, held in flops.
// Combinational read port, single-line synchronous write port.
module icache_line_store #(
  parameter int unsigned NumLines = 16,
  parameter int unsigned IndexW   = 4,
  parameter int unsigned TagW     = 24,
  parameter int unsigned LineW    = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IndexW-1:0] rd_index_i,
  output logic              rd_valid_o,
  output logic [TagW-1:0]   rd_tag_o,
  output logic [LineW-1:0]  rd_line_o,
  input  logic              we_i,
  input  logic [IndexW-1:0] wr_index_i,
  input  logic [TagW-1:0]   wr_tag_i,
  input  logic [LineW-1:0]  wr_line_i
);

  logic [NumLines-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [LineW-1:0]    data_q [NumLines];

  // Lookup is purely combinational so a hit can be registered in the request cycle.
  always_comb begin
    rd_valid_o = valid_q[rd_index_i];
    rd_tag_o   = tag_q[rd_index_i];
    rd_line_o  = data_q[rd_index_i];
  end

  // Valid bits are the only state that must be cleared; stale tags/data are masked by them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data payload, written together with the valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: answers IFQ line fetches, refilling misses from a
// 32-bit memory port in four beats.
module icache_dm
  import ifq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128,
  parameter int unsigned NUM_LINES        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       pc_in,
  input  logic                        rd_en,
  input  logic                        abort,
  output logic [CACHE_LINE_WIDTH-1:0] D_out,
  output logic                        d_out_valid,
  output logic                        busy,
  output logic                        mem_req,
  output logic [DATA_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ack,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  output logic [15:0]                 miss_cnt
);

  localparam int unsigned IdxW   = $clog2(NUM_LINES);
  localparam int unsigned TagW   = DATA_WIDTH - IdxW - OFFSET_W;
  localparam int unsigned FillW  = CACHE_LINE_WIDTH - DATA_WIDTH;
  localparam logic [1:0]  LastBeat = 2'(WORDS_PER_LINE - 1);

  icache_state_t               state_q;
  logic [1:0]                  beat_q;
  logic [FillW-1:0]            fill_q;
  logic                        abort_pend_q;
  logic [CACHE_LINE_WIDTH-1:0] dout_q;
  logic                        dout_valid_q;
  logic                        busy_q;
  logic                        mem_req_q;
  logic [DATA_WIDTH-1:0]       mem_addr_q;
  logic [15:0]                 miss_cnt_q;

  logic [IdxW-1:0]             pc_index;
  logic [TagW-1:0]             pc_tag;
  logic                        rd_valid;
  logic [TagW-1:0]             rd_tag;
  logic [CACHE_LINE_WIDTH-1:0] rd_line;
  logic                        hit;
  logic                        beat_done;
  logic                        fill_we;
  logic [CACHE_LINE_WIDTH-1:0] fill_line;
  logic [OFFSET_W-1:0]         unused_pc_offset;

  // Address split and hit detection for the incoming fetch.
  always_comb begin
    pc_index         = pc_in[OFFSET_W+IdxW-1:OFFSET_W];
    pc_tag           = pc_in[DATA_WIDTH-1:OFFSET_W+IdxW];
    unused_pc_offset = pc_in[OFFSET_W-1:0];
    hit              = rd_valid && (rd_tag == pc_tag);
    beat_done        = (state_q == REFILL) && mem_req_q && mem_ack;
    fill_we          = beat_done && (beat_q == LastBeat);
    // The last beat goes straight into the array alongside the three buffered words.
    fill_line        = {mem_data, fill_q};
  end

  icache_line_store #(
    .NumLines (NUM_LINES),
    .IndexW   (IdxW),
    .TagW     (TagW),
    .LineW    (CACHE_LINE_WIDTH)
  ) u_line_store (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rd_index_i (pc_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .we_i       (fill_we),
    .wr_index_i (mem_addr_q[OFFSET_W+IdxW-1:OFFSET_W]),
    .wr_tag_i   (mem_addr_q[DATA_WIDTH-1:OFFSET_W+IdxW]),
    .wr_line_i  (fill_line)
  );

  // Lookup/refill/respond FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      fill_q       <= '0;
      abort_pend_q <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      miss_cnt_q   <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          abort_pend_q <= 1'b0;
          if (rd_en) begin
            if (hit) begin
              dout_q       <= rd_line;
              dout_valid_q <= 1'b1;
            end else begin
              state_q    <= REFILL;
              busy_q     <= 1'b1;
              miss_cnt_q <= miss_cnt_q + 16'd1;
              beat_q     <= '0;
              mem_addr_q <= {pc_in[DATA_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
              mem_req_q  <= 1'b1;
            end
          end
        end
        REFILL: begin
          if (abort) begin
            abort_pend_q <= 1'b1;
          end
          if (beat_done) begin
            // Shift words in from the top so word 0 ends up in the low bits.
            fill_q <= {mem_data, fill_q[FillW-1:DATA_WIDTH]};
            beat_q <= beat_q + 2'd1;
            if (beat_q == LastBeat) begin
              mem_req_q    <= 1'b0;
              dout_q       <= fill_line;
              // An abort landing on the final beat cycle also suppresses the response.
              dout_valid_q <= !(abort_pend_q || abort);
              state_q      <= RESPOND;
            end else begin
              mem_addr_q <= mem_addr_q + DATA_WIDTH'(4);
            end
          end
        end
        RESPOND: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          abort_pend_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign D_out       = dout_q;
  assign d_out_valid = dout_valid_q;
  assign busy        = busy_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  pc_in = '0;
  logic         rd_en = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] D_out;
  logic         d_out_valid;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_data;
  logic [15:0]  miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_delay = 0;
  int wait_cnt  = 0;
  int valid_cnt = 0;
  logic [31:0] beat_log [$];

  localparam logic [127:0] LineA = 128'h000000A3_000000A2_000000A1_000000A0; // 0x100
  localparam logic [127:0] LineB = 128'h00000063_00000062_00000061_00000060; // 0x200
  localparam logic [127:0] LineC = 128'h00000027_00000026_00000025_00000024; // 0x310
  localparam logic [127:0] LineD = 128'h000001E3_000001E2_000001E1_000001E0; // 0x400
  localparam logic [127:0] LineE = 128'h000001A3_000001A2_000001A1_000001A0; // 0x500

  icache_dm u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .rd_en       (rd_en),
    .abort       (abort),
    .D_out       (D_out),
    .d_out_valid (d_out_valid),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents: word at byte address a is (a>>2) ^ 0xE0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'hE0;
  endfunction

  // Memory responder: acks after mem_delay waiting cycles per beat.
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wait_cnt >= mem_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(mem_addr);
          beat_log.push_back(mem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response pulse counter.
  initial forever begin
    @(negedge clk);
    if (d_out_valid === 1'b1) valid_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_resp(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d_out_valid === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic issue(input logic [31:0] addr);
    @(negedge clk);
    pc_in = addr;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", d_out_valid); end
    n_tests++; if (D_out !== 128'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", D_out); end
    n_tests++; if (miss_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_cold_miss;
    bit seen;
    mem_delay = 0;
    beat_log.delete();
    issue(32'h100);
    n_tests++; if (busy !== 1'b1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_start: busy=%b mem_req=%b want 1 1", busy, mem_req); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL cold_addr: got %h want 100", mem_addr); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    wait_resp(20, seen);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL cold_resp: no d_out_valid within budget, want one"); end
    n_tests++; if (D_out !== LineA) begin n_fail++; $display("FAIL cold_line: got %h want %h", D_out, LineA); end
    n_tests++; if (beat_log.size() != 4) begin n_fail++; $display("FAIL cold_beats: got %0d beats want 4", beat_log.size()); end
    for (int k = 0; k < 4 && k < beat_log.size(); k++) begin
      n_tests++;
      if (beat_log[k] !== 32'h100 + 32'(4 * k)) begin
        n_fail++; $display("FAIL cold_beat_addr%0d: got %h want %h", k, beat_log[k], 32'h100 + 32'(4 * k));
      end
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || d_out_valid !== 1'b0) begin n_fail++; $display("FAIL cold_after: busy=%b valid=%b want 0 0", busy, d_out_valid); end
  endtask

  task automatic test_hit;
    @(negedge clk);
    pc_in = 32'h108;
    rd_en = 1'b1;
    @(negedge clk);
    n_tests++; if (d_out_valid !== 1'b1 || D_out !== LineA) begin n_fail++; $display("FAIL hit_108: valid=%b line=%h want 1 %h", d_out_valid, D_out, LineA); end
    n_tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: mem_req=%b busy=%b want 0 0", mem_req, busy); end
    pc_in = 32'h10C;
    @(negedge clk);
    n_tests++; if (d_out_valid !== 1'b1 || D_out !== LineA) begin n_fail++; $display("FAIL hit_b2b_10c: valid=%b line=%h want 1 %h", d_out_valid, D_out, LineA); end
    pc_in = 32'h100;
    @(negedge clk);
    rd_en = 1'b0;
    n_tests++; if (d_out_valid !== 1'b1) begin n_fail++; $display("FAIL hit_b2b_100: valid=%b want 1", d_out_valid); end
    @(negedge clk);
    n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL hit_idle: valid=%b want 0", d_out_valid); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL hit_miss_cnt: got %0d want 1", miss_cnt); end
  endtask

  task automatic test_conflict;
    bit seen;
    issue(32'h200);
    n_tests++; if (busy !== 1'b1 || miss_cnt !== 16'd2) begin n_fail++; $display("FAIL conf_200_miss: busy=%b cnt=%0d want 1 2", busy, miss_cnt); end
    wait_resp(20, seen);
    n_tests++; if (!seen || D_out !== LineB) begin n_fail++; $display("FAIL conf_200_line: seen=%b line=%h want 1 %h", seen, D_out, LineB); end
    issue(32'h100);
    n_tests++; if (busy !== 1'b1 || miss_cnt !== 16'd3) begin n_fail++; $display("FAIL conf_100_remiss: busy=%b cnt=%0d want 1 3", busy, miss_cnt); end
    wait_resp(20, seen);
    n_tests++; if (!seen || D_out !== LineA) begin n_fail++; $display("FAIL conf_100_line: seen=%b line=%h want 1 %h", seen, D_out, LineA); end
  endtask

  task automatic test_abort;
    int vc0;
    mem_delay = 2;
    beat_log.delete();
    vc0 = valid_cnt;
    issue(32'h310);
    for (int i = 0; i < 100 && beat_log.size() < 2; i++) @(posedge clk);
    n_tests++; if (beat_log.size() != 2) begin n_fail++; $display("FAIL abort_beats01: got %0d beats want 2", beat_log.size()); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_done: busy=%b want 0", busy); end
    n_tests++; if (valid_cnt != vc0) begin n_fail++; $display("FAIL abort_no_resp: got %0d responses want 0", valid_cnt - vc0); end
    n_tests++; if (beat_log.size() != 4 || beat_log[beat_log.size()-1] !== 32'h31C) begin
      n_fail++; $display("FAIL abort_beats23: got %0d beats want 4 ending at 31c", beat_log.size());
    end
    n_tests++; if (miss_cnt !== 16'd4) begin n_fail++; $display("FAIL abort_miss_cnt: got %0d want 4", miss_cnt); end
    mem_delay = 0;
    issue(32'h314);
    n_tests++; if (d_out_valid !== 1'b1 || D_out !== LineC) begin n_fail++; $display("FAIL abort_line_hit: valid=%b line=%h want 1 %h", d_out_valid, D_out, LineC); end
    n_tests++; if (mem_req !== 1'b0 || miss_cnt !== 16'd4) begin n_fail++; $display("FAIL abort_hit_nomiss: mem_req=%b cnt=%0d want 0 4", mem_req, miss_cnt); end
  endtask

  task automatic test_reset_mid_refill;
    bit seen;
    mem_delay = 1;
    beat_log.delete();
    issue(32'h400);
    for (int i = 0; i < 100 && beat_log.size() < 2; i++) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: mem_req=%b busy=%b want 0 0", mem_req, busy); end
    n_tests++; if (miss_cnt !== 16'd0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_regs: cnt=%0d addr=%h want 0 0", miss_cnt, mem_addr); end
    @(negedge clk);
    rst = 1'b1;
    issue(32'h400);
    n_tests++; if (busy !== 1'b1 || miss_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_400_miss: busy=%b cnt=%0d want 1 1", busy, miss_cnt); end
    wait_resp(40, seen);
    n_tests++; if (!seen || D_out !== LineD) begin n_fail++; $display("FAIL rstmid_400_line: seen=%b line=%h want 1 %h", seen, D_out, LineD); end
    issue(32'h310);
    n_tests++; if (busy !== 1'b1 || miss_cnt !== 16'd2) begin n_fail++; $display("FAIL rstmid_valid_cleared: busy=%b cnt=%0d want 1 2", busy, miss_cnt); end
    wait_resp(40, seen);
    n_tests++; if (!seen || D_out !== LineC) begin n_fail++; $display("FAIL rstmid_310_line: seen=%b line=%h want 1 %h", seen, D_out, LineC); end
  endtask

  task automatic test_stall;
    int req_cycles;
    int addr_changes;
    int not_busy;
    bit seen;
    logic [31:0] prev;
    mem_delay = 5;
    @(negedge clk);
    pc_in = 32'h500;
    rd_en = 1'b1;
    @(negedge clk);
    // Keep requesting a different line; it must be ignored while busy.
    pc_in = 32'h108;
    n_tests++; if (busy !== 1'b1 || mem_addr !== 32'h500 || miss_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stall_start: busy=%b addr=%h cnt=%0d want 1 500 3", busy, mem_addr, miss_cnt);
    end
    req_cycles   = (mem_req === 1'b1) ? 1 : 0;
    addr_changes = 0;
    not_busy     = 0;
    seen         = 1'b0;
    prev         = mem_addr;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d_out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) not_busy++;
      if (mem_req === 1'b1) req_cycles++;
      if (mem_addr !== prev) addr_changes++;
      prev = mem_addr;
    end
    rd_en = 1'b0;
    n_tests++; if (!seen || D_out !== LineE) begin n_fail++; $display("FAIL stall_line: seen=%b line=%h want 1 %h", seen, D_out, LineE); end
    n_tests++; if (req_cycles != 24) begin n_fail++; $display("FAIL stall_req_cycles: got %0d want 24", req_cycles); end
    n_tests++; if (addr_changes != 3) begin n_fail++; $display("FAIL stall_addr_stable: got %0d changes want 3", addr_changes); end
    n_tests++; if (not_busy != 0) begin n_fail++; $display("FAIL stall_busy: got %0d idle cycles want 0", not_busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || miss_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_rd_en_ignored: busy=%b cnt=%0d want 0 3", busy, miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_abort();
    test_reset_mid_refill();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
